// File: rtl/nba_merge_arbiter_if.sv
// nba_merge_arbiter_if: request, bank-clear and read-port bundle of nba_merge_arbiter
interface nba_merge_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ*WIDTH-1:0] req_mask;
    logic                  clr_start;
    logic                  clr_busy;
    logic [AW-1:0]         rd_addr;
    logic [WIDTH-1:0]      rd_data;
    logic [31:0]           commit_cnt;
    modport master (
        output req_valid, req_addr, req_data, req_mask, clr_start, rd_addr,
        input  req_ready, clr_busy, rd_data, commit_cnt
    );
    modport slave (
        input  req_valid, req_addr, req_data, req_mask, clr_start, rd_addr,
        output req_ready, clr_busy, rd_data, commit_cnt
    );
endinterface

// File: rtl/nba_merge_arbiter.sv
// nba_merge_arbiter: merges same-address masked writes (highest index wins) into a register bank; NBA_MERGE_FWD_EN forwards commits/clears to the read port
module nba_merge_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 128,
    parameter int DEPTH = 8
) (
    input logic clk,
    input logic rst,
    nba_merge_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(NREQ);
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t           state;
    logic [WIDTH-1:0] bank [DEPTH];
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    lead;
    logic [PW-1:0]    j;
    logic [AW-1:0]    lead_addr;
    logic [AW-1:0]    clr_idx;
    logic [NREQ-1:0]  grant;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] rd_next;
    logic [31:0]      n_grant;
    // lead is the first valid requester scanning circularly from rr_ptr
    always_comb begin
        lead = rr_ptr;
        j = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = PW'((int'(rr_ptr) + k) % NREQ);
            if (bus.req_valid[j]) lead = j;
        end
    end
    // grant everyone aimed at the lead address and fold their writes in ascending index order
    always_comb begin
        lead_addr = '0;
        for (int i = 0; i < NREQ; i++)
            if (PW'(i) == lead) lead_addr = bus.req_addr[i*AW +: AW];
        grant = '0;
        merged = bank[lead_addr];
        n_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = !rst && state == IDLE && bus.req_valid[i] && bus.req_addr[i*AW +: AW] == lead_addr;
            if (grant[i]) begin
                merged = (merged & ~bus.req_mask[i*WIDTH +: WIDTH]) | (bus.req_data[i*WIDTH +: WIDTH] & bus.req_mask[i*WIDTH +: WIDTH]);
                n_grant = n_grant + 1;
            end
        end
    end
    assign bus.req_ready = grant;
`ifdef NBA_MERGE_FWD_EN
    assign rd_next = (state == IDLE && |grant && lead_addr == bus.rd_addr) ? merged :
                     (state == CLEAR && clr_idx == bus.rd_addr) ? '0 : bank[bus.rd_addr];
`else
    assign rd_next = bank[bus.rd_addr];
`endif
    // bank, round-robin pointer, clear sequencer, read port and commit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
            rr_ptr         <= '0;
            state          <= IDLE;
            clr_idx        <= '0;
            bus.rd_data    <= '0;
            bus.clr_busy   <= 1'b0;
            bus.commit_cnt <= '0;
        end else begin
            bus.rd_data <= rd_next;
            if (state == IDLE) begin
                if (|grant) begin
                    bank[lead_addr] <= merged;
                    rr_ptr         <= lead == PW'(NREQ - 1) ? '0 : lead + 1'b1;
                    bus.commit_cnt <= bus.commit_cnt + n_grant;
                end
                if (bus.clr_start) begin
                    state        <= CLEAR;
                    clr_idx      <= '0;
                    bus.clr_busy <= 1'b1;
                end
            end else begin
                bank[clr_idx] <= '0;
                clr_idx       <= clr_idx + 1'b1;
                if (clr_idx == AW'(DEPTH - 1)) begin
                    state        <= IDLE;
                    bus.clr_busy <= 1'b0;
                end
            end
        end
    end
endmodule
